// File: rtl/key_sw_input_ctrl_if.sv
// Register bus between a host (master) and the key/switch input block (slave).
// Single-cycle strobes; rdata is registered inside the slave.
interface key_sw_input_ctrl_if #(
    parameter int DBITS = 32
);
    logic [1:0]       reg_sel;
    logic             rd_en;
    logic             wr_en;
    logic [DBITS-1:0] wdata;
    logic [DBITS-1:0] rdata;

    modport master (
        output reg_sel, rd_en, wr_en, wdata,
        input  rdata
    );

    modport slave (
        input  reg_sel, rd_en, wr_en, wdata,
        output rdata
    );
endinterface

// File: rtl/key_sw_input_ctrl.sv
// Key/switch input controller: 2-flop synchronizers, per-bit debounce,
// change-detect ready/overrun status and a small polled register file.
// Optional interrupt output and ie bits are enabled by defining KEYSW_IRQ_EN.
module key_sw_input_ctrl #(
    parameter int DBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_raw,
    input  logic [9:0] sw_raw,
    output logic [3:0] key_in,
    output logic [9:0] sw_in,
`ifdef KEYSW_IRQ_EN
    output logic       irq,
`endif
    key_sw_input_ctrl_if.slave bus
);

    localparam int NB = 14;                            // 4 keys + 10 switches
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Raw level of a released key; also the synchronizer reset value.
    localparam logic [3:0] KEY_IDLE = KEY_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        SEL_KDATA = 2'd0,
        SEL_KCTRL = 2'd1,
        SEL_SDATA = 2'd2,
        SEL_SCTRL = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } stat_t;

    logic [3:0]    key_s1_q, key_s2_q;
    logic [9:0]    sw_s1_q, sw_s2_q;
    logic [NB-1:0] sync_vec;
    logic [NB-1:0] stable_q, stable_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    stat_t         kstat_q, kstat_d, sstat_q, sstat_d;
    logic [DBITS-1:0] rdata_q, rd_mux;
    logic          kchg, schg;
    logic          kread, sread, kctrl_wr, sctrl_wr;
    reg_sel_e      sel;
    logic          unused_wdata;

    // Next status for one group: software clears, then hardware change events win.
    function automatic stat_t stat_next(input stat_t cur, input logic chg,
                                        input logic rd, input logic wr,
                                        input logic [DBITS-1:0] wd);
        stat_t nxt;
        nxt = cur;
        if (wr && !wd[1]) nxt.ovr = 1'b0;
`ifdef KEYSW_IRQ_EN
        if (wr) nxt.ie = wd[8];
`endif
        if (chg && cur.rdy && !rd) nxt.ovr = 1'b1;
        if (chg)     nxt.rdy = 1'b1;
        else if (rd) nxt.rdy = 1'b0;
        return nxt;
    endfunction

    // Control register image: ie at bit 8, overrun at bit 1, ready at bit 0.
    function automatic logic [DBITS-1:0] ctrl_word(input stat_t s);
        logic [DBITS-1:0] w;
        w    = '0;
        w[8] = s.ie;
        w[1] = s.ovr;
        w[0] = s.rdy;
        return w;
    endfunction

    assign sel          = reg_sel_e'(bus.reg_sel);
    assign kread        = bus.rd_en && (sel == SEL_KDATA);
    assign sread        = bus.rd_en && (sel == SEL_SDATA);
    assign kctrl_wr     = bus.wr_en && (sel == SEL_KCTRL);
    assign sctrl_wr     = bus.wr_en && (sel == SEL_SCTRL);
    assign unused_wdata = ^bus.wdata;

    // Keys are flipped to 1 = pressed once they are safely in the clk domain.
    assign sync_vec = {sw_s2_q, key_s2_q ^ KEY_IDLE};

    assign key_in   = stable_q[3:0];
    assign sw_in    = stable_q[13:4];
    assign bus.rdata = rdata_q;

    // Two-flop synchronizers; reset to the released level so nothing looks pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1_q <= KEY_IDLE;
            key_s2_q <= KEY_IDLE;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            // NOTE: non-blocking here so s2 takes s1's old value, giving two real stages.
            key_s1_q <= key_raw;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Per-bit debounce: accept a new level only after it has held for the full count.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync_vec[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) stable_d[i] = sync_vec[i];
                else                      cnt_d[i]    = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Change detect and status next-state for both groups.
    always_comb begin
        kchg    = (stable_d[3:0]  != stable_q[3:0]);
        schg    = (stable_d[13:4] != stable_q[13:4]);
        kstat_d = stat_next(kstat_q, kchg, kread, kctrl_wr, bus.wdata);
        sstat_d = stat_next(sstat_q, schg, sread, sctrl_wr, bus.wdata);
    end

    // Read mux over the current (pre-update) state.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_KDATA: rd_mux[3:0] = key_in;
            SEL_KCTRL: rd_mux      = ctrl_word(kstat_q);
            SEL_SDATA: rd_mux[9:0] = sw_in;
            SEL_SCTRL: rd_mux      = ctrl_word(sstat_q);
            default:   rd_mux      = '0;
        endcase
    end

    // Debounce state, status bits and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the small counter array is reset too, so a press in progress is dropped.
            stable_q <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
            kstat_q  <= '0;
            sstat_q  <= '0;
            rdata_q  <= '0;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            kstat_q  <= kstat_d;
            sstat_q  <= sstat_d;
            if (bus.rd_en) rdata_q <= rd_mux;
        end
    end

`ifdef KEYSW_IRQ_EN
    logic irq_q;

    // Interrupt follows the enabled ready bits one cycle late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (kstat_q.rdy & kstat_q.ie) | (sstat_q.rdy & sstat_q.ie);
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_key_sw_input_ctrl.sv
// Directed bench for key_sw_input_ctrl with DEBOUNCE_CYCLES = 4.
// Register reads push their expected value to a scoreboard queue and are
// compared when rdata is produced one cycle later.
module tb_key_sw_input_ctrl;

    localparam int DBITS = 32;
    localparam int DEB   = 4;
    localparam logic [1:0] KDATA = 2'd0, KCTRL = 2'd1, SDATA = 2'd2, SCTRL = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_raw = 4'hF;
    logic [9:0] sw_raw = '0;
    logic [3:0] key_in;
    logic [9:0] sw_in;
`ifdef KEYSW_IRQ_EN
    logic       irq;
`endif

    key_sw_input_ctrl_if #(.DBITS(DBITS)) bus_if();

    key_sw_input_ctrl #(
        .DBITS(DBITS),
        .DEBOUNCE_CYCLES(DEB),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_raw(key_raw),
        .sw_raw(sw_raw),
        .key_in(key_in),
        .sw_in(sw_in),
`ifdef KEYSW_IRQ_EN
        .irq(irq),
`endif
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [DBITS-1:0] exp_q[$];
    string            tag_q[$];
    logic [9:0]       exp_sw;

    task automatic check(input string tag, input logic [DBITS-1:0] obs,
                         input logic [DBITS-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic access(input string tag, input logic [1:0] sel, input logic rd,
                          input logic wr, input logic [DBITS-1:0] wd,
                          input logic [DBITS-1:0] exp);
        bus_if.reg_sel = sel;
        bus_if.rd_en   = rd;
        bus_if.wr_en   = wr;
        bus_if.wdata   = wd;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        step();
        bus_if.rd_en = 1'b0;
        bus_if.wr_en = 1'b0;
        if (rd) check(tag_q.pop_front(), bus_if.rdata, exp_q.pop_front());
    endtask

    task automatic rd(input string tag, input logic [1:0] sel, input logic [DBITS-1:0] exp);
        access(tag, sel, 1'b1, 1'b0, '0, exp);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [DBITS-1:0] wd);
        access("write", sel, 1'b0, 1'b1, wd, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.reg_sel = '0;
        bus_if.rd_en   = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wdata   = '0;

        // Asynchronous reset between clock edges.
        #3 reset = 1'b1;
        #1;
        check("rst_key_in", 32'(key_in), 32'h0);
        check("rst_sw_in", 32'(sw_in), 32'h0);
        check("rst_rdata", bus_if.rdata, 32'h0);
        step();
        reset = 1'b0;
        rd("rst_kctrl", KCTRL, 32'h0);
        check("rst_key_idle", 32'(key_in), 32'h0);

        // Clean press of key 0: visible exactly 2 + DEB cycles after the edge.
        key_raw = 4'hE;
        step(5);
        check("press_early", 32'(key_in), 32'h0);
        step();
        check("press_on_time", 32'(key_in), 32'h1);
        rd("press_kctrl", KCTRL, 32'h1);
        rd("press_kdata", KDATA, 32'h1);
        rd("press_kctrl_clr", KCTRL, 32'h0);
        step(2);
        check("rdata_hold", bus_if.rdata, 32'h0);

        // Glitch of 3 cycles is rejected.
        sw_raw = 10'h008;
        step(3);
        sw_raw = 10'h000;
        step(8);
        check("glitch_sw_in", 32'(sw_in), 32'h0);
        rd("glitch_sctrl", SCTRL, 32'h0);

        // Held level is accepted.
        sw_raw = 10'h008;
        step(5);
        check("sw_early", 32'(sw_in), 32'h0);
        step();
        check("sw_accept", 32'(sw_in), 32'h008);
        rd("sw_sctrl", SCTRL, 32'h1);
        rd("sw_sdata", SDATA, 32'h008);
        rd("sw_sctrl_clr", SCTRL, 32'h0);

        // Overrun: two key changes without a data read.
        key_raw = 4'hC;
        step(6);
        check("ovr_press", 32'(key_in), 32'h3);
        key_raw = 4'hE;
        step(6);
        check("ovr_release", 32'(key_in), 32'h1);
        rd("ovr_kctrl", KCTRL, 32'h3);
        access("ovr_rw_same", KCTRL, 1'b1, 1'b1, 32'h0, 32'h3);
        rd("ovr_cleared", KCTRL, 32'h1);
        rd("ovr_kdata", KDATA, 32'h1);
        rd("ovr_all_clear", KCTRL, 32'h0);

        // Data read lands in the very cycle the key change is accepted.
        key_raw = 4'hF;
        step(5);
        rd("same_kdata_old", KDATA, 32'h1);
        check("same_key_in", 32'(key_in), 32'h0);
        rd("same_kctrl", KCTRL, 32'h1);
        rd("same_kdata_new", KDATA, 32'h0);
        rd("same_kctrl_clr", KCTRL, 32'h0);

`ifdef KEYSW_IRQ_EN
        wr(SCTRL, 32'h100);
        rd("irq_sctrl_ie", SCTRL, 32'h100);
        check("irq_idle", 32'(irq), 32'h0);
        sw_raw = 10'h009;
        step(6);
        check("irq_sw_in", 32'(sw_in), 32'h009);
        check("irq_not_yet", 32'(irq), 32'h0);
        step();
        check("irq_rise", 32'(irq), 32'h1);
        rd("irq_sdata", SDATA, 32'h009);
        check("irq_still_high", 32'(irq), 32'h1);
        step();
        check("irq_fall", 32'(irq), 32'h0);
        rd("irq_sctrl_after", SCTRL, 32'h100);
        exp_sw = 10'h009;
`else
        wr(KCTRL, 32'h100);
        rd("no_ie_kctrl", KCTRL, 32'h0);
        exp_sw = 10'h008;
`endif

        // Reset mid-debounce drops the partial count; held inputs requalify.
        key_raw = 4'hB;
        step(4);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_key_in", 32'(key_in), 32'h0);
        check("mid_rst_sw_in", 32'(sw_in), 32'h0);
        check("mid_rst_rdata", bus_if.rdata, 32'h0);
        step();
        reset = 1'b0;
        step(5);
        check("requal_key_early", 32'(key_in), 32'h0);
        check("requal_sw_early", 32'(sw_in), 32'h0);
        step();
        check("requal_key", 32'(key_in), 32'h4);
        check("requal_sw", 32'(sw_in), 32'(exp_sw));
        rd("requal_kctrl", KCTRL, 32'h1);
        rd("requal_sctrl", SCTRL, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
